// File: rtl/instruction_cache_dm.sv
// Direct-mapped L1 instruction cache with multi-beat L2 line refill and fence.i invalidate.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module instruction_cache_dm #(
  parameter int   ADDRESS_WIDTH  = 32,
  parameter int   DATA_WIDTH     = 32,
  parameter int   L2_BUS_WIDTH   = 32,
  parameter int   CACHE_DEPTH    = 64,
  parameter int   WORDS_PER_LINE = 4,
  parameter logic HIGH           = 1'b1,
  parameter logic LOW            = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     STALL_INSTRUCTION_CACHE,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  input  logic                     PC_VALID,
  input  logic                     INVALIDATE,
  output logic [DATA_WIDTH-1:0]    INSTRUCTION,
  output logic                     INSTRUCTION_CACHE_READY,
  input  logic                     ADDRESS_TO_L2_READY_INS,
  output logic                     ADDRESS_TO_L2_VALID_INS,
  output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_READY_INS,
  input  logic                     DATA_FROM_L2_VALID_INS,
  input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]              HIT_COUNT,
  output logic [31:0]              MISS_COUNT
`endif
);
  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(CACHE_DEPTH);
  localparam int TAG_W    = ADDRESS_WIDTH - 2 - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, REQUEST, REFILL} state_t;

  state_t                  state_q, state_d;
  logic [CACHE_DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [INDEX_W-1:0]      idx_q, idx_d;
  logic [OFFSET_W-1:0]     off_q, off_d;
  logic [OFFSET_W-1:0]     beat_q, beat_d;
  logic                    pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;

  logic [TAG_W-1:0]        tag_mem  [CACHE_DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [CACHE_DEPTH*WORDS_PER_LINE];

  logic [OFFSET_W-1:0]     pc_off;
  logic [INDEX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic                    lookup, hit, beat_fire, last_beat;
  logic                    unused_pc_bits;

  assign pc_off         = PC[2 +: OFFSET_W];
  assign pc_idx         = PC[2+OFFSET_W +: INDEX_W];
  assign pc_tag         = PC[ADDRESS_WIDTH-1 -: TAG_W];
  assign unused_pc_bits = ^PC[1:0];

  assign lookup    = (state_q == IDLE) && PC_VALID && !STALL_INSTRUCTION_CACHE;
  // An invalidate on the lookup edge wins: the line is treated as gone.
  assign hit       = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag) && !INVALIDATE;
  assign beat_fire = (state_q == REFILL) && DATA_FROM_L2_VALID_INS;
  assign last_beat = beat_fire && (beat_q == OFFSET_W'(WORDS_PER_LINE-1));

  always_comb begin
    state_d                 = state_q;
    valid_d                 = INVALIDATE ? '0 : valid_q;
    tag_d                   = tag_q;
    idx_d                   = idx_q;
    off_d                   = off_q;
    beat_d                  = beat_q;
    pend_d                  = pend_q;
    instr_d                 = instr_q;
    INSTRUCTION_CACHE_READY = LOW;
    ADDRESS_TO_L2_VALID_INS = LOW;
    DATA_FROM_L2_READY_INS  = LOW;
    ADDRESS_TO_L2_INS       = {tag_q, idx_q, {OFFSET_W{LOW}}};
    case (state_q)
      IDLE: begin
        INSTRUCTION_CACHE_READY = HIGH;
        if (lookup) begin
          if (hit) begin
            instr_d = data_mem[{pc_idx, pc_off}];
          end else begin
            tag_d   = pc_tag;
            idx_d   = pc_idx;
            off_d   = pc_off;
            beat_d  = '0;
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        ADDRESS_TO_L2_VALID_INS = HIGH;
        if (INVALIDATE) pend_d = HIGH;
        if (ADDRESS_TO_L2_READY_INS) state_d = REFILL;
      end
      REFILL: begin
        DATA_FROM_L2_READY_INS = HIGH;
        if (INVALIDATE) pend_d = HIGH;
        if (beat_fire) begin
          beat_d = beat_q + OFFSET_W'(1);
          if (beat_q == off_q) instr_d = DATA_FROM_L2_INS;
          if (last_beat) begin
            state_d = IDLE;
            pend_d  = LOW;
            // A fence.i seen at any point during the refill leaves the line invalid.
            if (!pend_q && !INVALIDATE) valid_d[idx_q] = HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (beat_fire) data_mem[{idx_q, beat_q}] <= DATA_FROM_L2_INS;
    if (last_beat) tag_mem[idx_q] <= tag_q;
  end

  assign INSTRUCTION = instr_q;

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup) begin
      if (hit && hit_cnt_q != '1)    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit && miss_cnt_q != '1)  miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_cache_dm.sv
// Randomised bench for instruction_cache_dm: a line-presence model plus a pure function for L2 contents.
module tb_instruction_cache_dm;
  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL_INSTRUCTION_CACHE;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        INVALIDATE;
  logic [31:0] INSTRUCTION;
  logic        INSTRUCTION_CACHE_READY;
  logic        ADDRESS_TO_L2_READY_INS;
  logic        ADDRESS_TO_L2_VALID_INS;
  logic [29:0] ADDRESS_TO_L2_INS;
  logic        DATA_FROM_L2_READY_INS;
  logic        DATA_FROM_L2_VALID_INS;
  logic [31:0] DATA_FROM_L2_INS;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  instruction_cache_dm dut (
    .CLK(CLK), .RST(RST), .STALL_INSTRUCTION_CACHE(STALL_INSTRUCTION_CACHE),
    .PC(PC), .PC_VALID(PC_VALID), .INVALIDATE(INVALIDATE),
    .INSTRUCTION(INSTRUCTION), .INSTRUCTION_CACHE_READY(INSTRUCTION_CACHE_READY),
    .ADDRESS_TO_L2_READY_INS(ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_VALID_INS(ADDRESS_TO_L2_VALID_INS),
    .ADDRESS_TO_L2_INS(ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_READY_INS(DATA_FROM_L2_READY_INS),
    .DATA_FROM_L2_VALID_INS(DATA_FROM_L2_VALID_INS),
    .DATA_FROM_L2_INS(DATA_FROM_L2_INS)
`ifdef ICACHE_PERF_COUNTERS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          mvalid [64];
  logic [27:0] mline  [64];
  logic [31:0] last_ins;

  // L2 backing store: word contents are a fixed function of the word address.
  function automatic logic [31:0] l2w(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h0100_0193) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input int hold, input int maxgap,
                       input bit inval_mid, input bit inval_now);
    int          idx;
    logic [27:0] line;
    bit          hit;
    idx  = int'(pc[9:4]);
    line = pc[31:4];
    if (inval_now) model_clear();
    hit  = mvalid[idx] && (mline[idx] == line);
    PC = pc; PC_VALID = 1'b1; INVALIDATE = inval_now;
    step();
    PC_VALID = 1'b0; INVALIDATE = 1'b0;
    if (hit) begin
      chk("hit_rdy", INSTRUCTION_CACHE_READY, 1);
      chk("hit_instr", INSTRUCTION, l2w(pc[31:2]));
      chk("hit_noreq", ADDRESS_TO_L2_VALID_INS, 0);
    end else begin
      chk("miss_rdy", INSTRUCTION_CACHE_READY, 0);
      chk("req_vld", ADDRESS_TO_L2_VALID_INS, 1);
      chk("req_addr", ADDRESS_TO_L2_INS, {2'b00, pc[31:4], 2'b00});
      for (int h = 0; h < hold; h++) begin
        ADDRESS_TO_L2_READY_INS = 1'b0;
        step();
        chk("hold_vld", ADDRESS_TO_L2_VALID_INS, 1);
        chk("hold_addr", ADDRESS_TO_L2_INS, {2'b00, pc[31:4], 2'b00});
      end
      ADDRESS_TO_L2_READY_INS = 1'b1;
      step();
      ADDRESS_TO_L2_READY_INS = 1'b0;
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, maxgap)) step();
        chk("fill_drdy", DATA_FROM_L2_READY_INS, 1);
        DATA_FROM_L2_VALID_INS = 1'b1;
        DATA_FROM_L2_INS = l2w({pc[31:4], 2'(b)});
        INVALIDATE = inval_mid && (b == 1);
        step();
        DATA_FROM_L2_VALID_INS = 1'b0;
        INVALIDATE = 1'b0;
        chk("fill_rdy", INSTRUCTION_CACHE_READY, (b == 3) ? 1 : 0);
      end
      chk("miss_instr", INSTRUCTION, l2w(pc[31:2]));
      if (inval_mid) model_clear();
      mline[idx]  = line;
      mvalid[idx] = !inval_mid;
    end
    last_ins = l2w(pc[31:2]);
  endtask

  initial begin
    RST = 1'b1; STALL_INSTRUCTION_CACHE = 1'b0; PC = '0; PC_VALID = 1'b0;
    INVALIDATE = 1'b0; ADDRESS_TO_L2_READY_INS = 1'b0;
    DATA_FROM_L2_VALID_INS = 1'b0; DATA_FROM_L2_INS = '0;
    model_clear();
    step(); step();
    chk("rst_instr", INSTRUCTION, 0);
    chk("rst_rdy", INSTRUCTION_CACHE_READY, 1);
    chk("rst_avld", ADDRESS_TO_L2_VALID_INS, 0);
    chk("rst_addr", ADDRESS_TO_L2_INS, 0);
    chk("rst_drdy", DATA_FROM_L2_READY_INS, 0);
    RST = 1'b0;
    step();

    fetch(32'h10, 0, 0, 0, 0);           // cold miss, address 0x4
    fetch(32'h18, 0, 0, 0, 0);           // hit in same line
    for (int i = 0; i < 4; i++) begin    // back-to-back hits
      PC = 32'h10 + 32'(4*i); PC_VALID = 1'b1;
      step();
      chk("b2b_instr", INSTRUCTION, l2w(PC[31:2]));
      chk("b2b_rdy", INSTRUCTION_CACHE_READY, 1);
    end
    PC_VALID = 1'b0;
    fetch(32'h410, 0, 0, 0, 0);          // conflict, address 0x104
    fetch(32'h10, 0, 0, 0, 0);           // evicted, misses again
    fetch(32'h24, 5, 2, 0, 0);           // address held off, gappy beats
    fetch(32'h1C, 0, 1, 1, 1);           // fence.i on lookup and mid-refill
    fetch(32'h10, 0, 0, 0, 0);           // not kept valid

    STALL_INSTRUCTION_CACHE = 1'b1; PC = 32'h30; PC_VALID = 1'b1;
    step();
    chk("stall_instr", INSTRUCTION, last_ins);
    chk("stall_noreq", ADDRESS_TO_L2_VALID_INS, 0);
    STALL_INSTRUCTION_CACHE = 1'b0; PC_VALID = 1'b0;

    INVALIDATE = 1'b1; step(); INVALIDATE = 1'b0; model_clear();
    PC = 32'h10; PC_VALID = 1'b1; step(); PC_VALID = 1'b0;
    ADDRESS_TO_L2_READY_INS = 1'b1; step(); ADDRESS_TO_L2_READY_INS = 1'b0;
    for (int b = 0; b < 2; b++) begin
      DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = l2w({28'h1, 2'(b)});
      step();
    end
    DATA_FROM_L2_VALID_INS = 1'b0;
    RST = 1'b1; #2;
    chk("mrst_instr", INSTRUCTION, 0);
    chk("mrst_rdy", INSTRUCTION_CACHE_READY, 1);
    chk("mrst_avld", ADDRESS_TO_L2_VALID_INS, 0);
    chk("mrst_drdy", DATA_FROM_L2_READY_INS, 0);
    step(); RST = 1'b0; model_clear();
    step();
    fetch(32'h10, 0, 0, 0, 0);
    fetch(32'h14, 0, 0, 0, 0);
    fetch(32'h18, 0, 0, 0, 0);
`ifdef ICACHE_PERF_COUNTERS_EN
    chk("hit_count", HIT_COUNT, 2);
    chk("miss_count", MISS_COUNT, 1);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      fetch(pc, $urandom_range(0, 2), 2, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
